// File: rtl/canvas_pkg.sv
// Shared constants for the drawing canvas: FSM encoding, KEY bit positions,
// ink value and width helper.
package canvas_pkg;

  typedef logic [1:0] canvas_state_t;

  localparam canvas_state_t ST_IDLE  = 2'd0;
  localparam canvas_state_t ST_CLEAR = 2'd1;
  localparam canvas_state_t ST_DUMP  = 2'd2;

  localparam int KEY_DOWN  = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  // Sliced down to PIX_BITS by the user; all-ones means full ink.
  localparam logic [63:0] INK_FULL = '1;

  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/canvas_if.sv
// Canvas dump stream. A beat transfers on a rising edge where out_valid and
// out_ready are both high; once out_valid rises, out_data/out_last hold until that transfer.
interface canvas_if #(
  parameter int PIX_BITS = 8
);
  logic                out_valid;
  logic                out_ready;
  logic [PIX_BITS-1:0] out_data;
  logic                out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/canvas_ram.sv
// Canvas storage: one synchronous write port, an always-enabled VGA read port
// and an enabled dump read port whose output holds while the stream stalls.
module canvas_ram #(
  parameter int DEPTH = 784,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_q_a,
  input  logic          i_re_b,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_q_b
);
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_q_a <= r_mem[i_raddr_a];
    if (i_re_b) o_q_b <= r_mem[i_raddr_b];
  end
endmodule

// File: rtl/canvas_engine.sv
// Drawing canvas: KEY-driven cursor with auto-repeat, draw/erase ink, clear
// sweep, VGA read port and a row-major dump stream for the NN loader.
module canvas_engine
  import canvas_pkg::*;
#(
  parameter  int GRID_W       = 28,
  parameter  int GRID_H       = 28,
  parameter  int PIX_BITS     = 8,
  parameter  int REPEAT_DELAY = 25000000,
  parameter  int REPEAT_RATE  = 5000000,
  localparam int X_W          = bits_for(GRID_W),
  localparam int Y_W          = bits_for(GRID_H),
  localparam int N            = GRID_W * GRID_H,
  localparam int ADDR_W       = bits_for(N)
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [3:0]          key_n,
  input  logic                draw_en,
  input  logic                erase_en,
  input  logic                clear_req,
  input  logic                dump_req,
  input  logic [X_W-1:0]      rd_x,
  input  logic [Y_W-1:0]      rd_y,
  output logic [PIX_BITS-1:0] rd_data,
  output logic [X_W-1:0]      cursor_x,
  output logic [Y_W-1:0]      cursor_y,
  output logic                busy,
  output canvas_state_t       o_dbg_state,
  canvas_if.master            o_stream
);
  localparam int CNT_W = bits_for(REPEAT_DELAY + 1);
  localparam logic [X_W-1:0]      X_MAX     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]      Y_MAX     = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0]      X_MID     = X_W'(GRID_W / 2);
  localparam logic [Y_W-1:0]      Y_MID     = Y_W'(GRID_H / 2);
  localparam logic [ADDR_W-1:0]   ADDR_LAST = ADDR_W'(N - 1);
  localparam logic [PIX_BITS-1:0] INK       = INK_FULL[PIX_BITS-1:0];
  // Counter reloads so the next hit lands REPEAT_RATE cycles later (needs RATE <= DELAY).
  localparam logic [CNT_W-1:0]    CNT_HIT   = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0]    CNT_RELD  = CNT_W'(REPEAT_DELAY - REPEAT_RATE + 1);

  canvas_state_t       r_state;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic [X_W-1:0]      r_cur_x;
  logic [Y_W-1:0]      r_cur_y;
  logic [3:0]          r_sync1, r_sync2, r_prev, r_step;
  logic [CNT_W-1:0]    r_cnt [4];
  logic [3:0]          w_hit;
  logic                w_idle, w_dumping;
  logic [ADDR_W-1:0]   w_cur_addr, w_rd_addr, w_waddr;
  logic                w_rd_ok, r_rd_ok, w_we;
  logic [PIX_BITS-1:0] w_wdata, w_q_a, w_q_b;
  logic [ADDR_W-1:0]   r_fetch;
  logic                r_fetch_done, r_q_vld, r_q_last;
  logic                r_out_valid, r_out_last;
  logic [PIX_BITS-1:0] r_out_data;
  logic                w_out_adv, w_ren;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_dumping   = (r_state == ST_DUMP);
  assign busy        = !w_idle;
  assign o_dbg_state = r_state;
  assign cursor_x    = r_cur_x;
  assign cursor_y    = r_cur_y;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear_req) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
          end else if (dump_req) begin
            r_state <= ST_DUMP;
          end
        end
        ST_CLEAR: begin
          if (r_clr_addr == ADDR_LAST) begin
            r_state    <= ST_IDLE;
            r_clr_addr <= '0;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        ST_DUMP: if (r_out_valid && o_stream.out_ready && r_out_last) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A step fires on a fresh press or when the held-key counter reaches its mark.
  always_comb begin
    for (int k = 0; k < 4; k++)
      w_hit[k] = w_idle && r_sync2[k] && (!r_prev[k] || (r_cnt[k] == CNT_HIT));
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_step  <= '0;
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      r_sync1 <= ~key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_step  <= w_hit;
      for (int k = 0; k < 4; k++) begin
        if (!r_sync2[k] || !w_idle) r_cnt[k] <= '0;
        else if (r_cnt[k] == CNT_HIT) r_cnt[k] <= CNT_RELD;
        else r_cnt[k] <= r_cnt[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_cur_x <= X_MID;
      r_cur_y <= Y_MID;
    end else if (w_idle) begin
      if (clear_req) begin
        r_cur_x <= X_MID;
        r_cur_y <= Y_MID;
      end else begin
        if (r_step[KEY_RIGHT] && !r_step[KEY_LEFT] && (r_cur_x != X_MAX)) r_cur_x <= r_cur_x + 1'b1;
        else if (r_step[KEY_LEFT] && !r_step[KEY_RIGHT] && (r_cur_x != '0)) r_cur_x <= r_cur_x - 1'b1;
        if (r_step[KEY_DOWN] && !r_step[KEY_UP] && (r_cur_y != Y_MAX)) r_cur_y <= r_cur_y + 1'b1;
        else if (r_step[KEY_UP] && !r_step[KEY_DOWN] && (r_cur_y != '0)) r_cur_y <= r_cur_y - 1'b1;
      end
    end
  end

  assign w_cur_addr = ADDR_W'(r_cur_y) * ADDR_W'(GRID_W) + ADDR_W'(r_cur_x);

  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_cur_addr;
    w_wdata = '0;
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
    end else if (w_idle && (erase_en || draw_en)) begin
      w_we    = 1'b1;
      w_wdata = erase_en ? '0 : INK;
    end
  end

  assign w_rd_ok   = (rd_x <= X_MAX) && (rd_y <= Y_MAX);
  assign w_rd_addr = w_rd_ok ? (ADDR_W'(rd_y) * ADDR_W'(GRID_W) + ADDR_W'(rd_x)) : '0;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_rd_ok <= 1'b0;
    else         r_rd_ok <= w_rd_ok;
  end

  assign rd_data = r_rd_ok ? w_q_a : '0;

  // Two-stage dump pipe: RAM output stage then output register; RAM read
  // stalls whenever its result cannot move forward, so no data is lost.
  assign w_out_adv = !r_out_valid || o_stream.out_ready;
  assign w_ren     = w_dumping && !r_fetch_done && (!r_q_vld || w_out_adv);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_fetch      <= '0;
      r_fetch_done <= 1'b0;
      r_q_vld      <= 1'b0;
      r_q_last     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= '0;
    end else if (!w_dumping) begin
      r_fetch      <= '0;
      r_fetch_done <= 1'b0;
      r_q_vld      <= 1'b0;
      r_q_last     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
    end else begin
      if (w_ren) begin
        r_q_last <= (r_fetch == ADDR_LAST);
        if (r_fetch == ADDR_LAST) r_fetch_done <= 1'b1;
        else                      r_fetch      <= r_fetch + 1'b1;
      end
      r_q_vld <= w_ren || (r_q_vld && !w_out_adv);
      if (w_out_adv) begin
        r_out_valid <= r_q_vld;
        r_out_last  <= r_q_vld && r_q_last;
        if (r_q_vld) r_out_data <= w_q_b;
      end
    end
  end

  assign o_stream.out_valid = r_out_valid;
  assign o_stream.out_data  = r_out_data;
  assign o_stream.out_last  = r_out_last;

  canvas_ram #(.DEPTH(N), .AW(ADDR_W), .DW(PIX_BITS)) u_ram (
    .i_clk     (CLOCK_50),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_rd_addr),
    .o_q_a     (w_q_a),
    .i_re_b    (w_ren),
    .i_raddr_b (r_fetch),
    .o_q_b     (w_q_b)
  );
endmodule

// File: tb/tb_canvas_engine.sv
// Bench for canvas_engine: reset/clear timing, key stepping and repeat,
// ink table, random ink ops against a canvas model, dump stream and aborts.
module tb_canvas_engine;
  localparam int GW = 28;
  localparam int GH = 28;
  localparam int NC = GW * GH;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] key_n;
  logic       draw_en, erase_en, clear_req, dump_req;
  logic [4:0] rd_x, rd_y, cursor_x, cursor_y;
  logic [7:0] rd_data;
  logic       busy;
  logic [1:0] dbg_state;

  canvas_if #(.PIX_BITS(8)) s_if ();

  canvas_engine #(
    .GRID_W(GW), .GRID_H(GH), .PIX_BITS(8), .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .key_n(key_n), .draw_en(draw_en), .erase_en(erase_en),
    .clear_req(clear_req), .dump_req(dump_req), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy), .o_dbg_state(dbg_state),
    .o_stream(s_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    logic       draw;
    logic       erase;
    logic [7:0] exp;
  } ink_vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model_mem [NC];
  logic [7:0] exp_q [$];
  int         m_x, m_y;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic tap(input logic [3:0] mask);
    key_n = ~mask;
    repeat (3) tick();
    key_n = 4'hF;
    repeat (4) tick();
  endtask

  task automatic hold(input logic [3:0] mask, input int ncyc);
    key_n = ~mask;
    repeat (ncyc) tick();
    key_n = 4'hF;
    repeat (4) tick();
  endtask

  task automatic move_to(input int tx, input int ty);
    while (m_x < tx) begin tap(4'b1000); m_x++; end
    while (m_x > tx) begin tap(4'b0100); m_x--; end
    while (m_y < ty) begin tap(4'b0001); m_y++; end
    while (m_y > ty) begin tap(4'b0010); m_y--; end
    check("move_x", int'(cursor_x), tx);
    check("move_y", int'(cursor_y), ty);
  endtask

  task automatic ink_op(input logic d, input logic e);
    draw_en  = d;
    erase_en = e;
    tick();
    draw_en  = 1'b0;
    erase_en = 1'b0;
    if (e)      model_mem[m_y * GW + m_x] = 8'h00;
    else if (d) model_mem[m_y * GW + m_x] = 8'hFF;
  endtask

  task automatic scan_vs_model(input string name);
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) begin
        rd_x = 5'(x);
        rd_y = 5'(y);
        tick();
        check(name, int'(rd_data), int'(model_mem[y * GW + x]));
      end
  endtask

  task automatic run_dump(input bit rand_ready);
    int beat, cyc, wait_n, first_c, last_c;
    bit stalled;
    logic [7:0] held_d, exp_d;
    logic held_l;
    exp_q.delete();
    for (int i = 0; i < NC; i++) exp_q.push_back(model_mem[i]);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_n = 0;
    while (!s_if.out_valid && wait_n < 10) begin
      tick();
      wait_n++;
    end
    check("dump_first_valid_latency_ok", int'(wait_n <= 2), 1);
    beat = 0; cyc = 0; stalled = 0; first_c = 0; last_c = 0;
    held_d = '0; held_l = 1'b0;
    while (exp_q.size() > 0 && cyc < 20000) begin
      s_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        check("stall_valid_held", int'(s_if.out_valid), 1);
        check("stall_data_held", int'(s_if.out_data), int'(held_d));
        check("stall_last_held", int'(s_if.out_last), int'(held_l));
      end
      if (s_if.out_valid && s_if.out_ready) begin
        exp_d = exp_q.pop_front();
        check("dump_data", int'(s_if.out_data), int'(exp_d));
        check("dump_last", int'(s_if.out_last), int'(exp_q.size() == 0));
        if (beat == 0) first_c = cyc;
        last_c  = cyc;
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = s_if.out_valid;
        held_d  = s_if.out_data;
        held_l  = s_if.out_last;
      end
      tick();
      cyc++;
    end
    s_if.out_ready = 1'b0;
    check("dump_beat_count", beat, NC);
    check("dump_done_busy", int'(busy), 0);
    check("dump_done_valid", int'(s_if.out_valid), 0);
    if (!rand_ready) check("dump_zero_bubble_span", last_c - first_c, NC - 1);
  endtask

  initial begin
    ink_vec_t   vecs [8];
    int         n, prev, c;
    int         step_t [$];
    bit         saw_valid;
    int         rx, ry, op;

    resetn = 1'b0; key_n = 4'hF; draw_en = 1'b0; erase_en = 1'b0;
    clear_req = 1'b0; dump_req = 1'b0; rd_x = '0; rd_y = '0; s_if.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", int'(busy), 1);
    check("rst_valid", int'(s_if.out_valid), 0);
    check("rst_last", int'(s_if.out_last), 0);
    check("rst_data", int'(s_if.out_data), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_cursor_x", int'(cursor_x), 14);
    check("rst_cursor_y", int'(cursor_y), 14);
    resetn = 1'b1;
    count_busy(n);
    check("reset_clear_len", n, NC);
    m_x = 14; m_y = 14;
    for (int i = 0; i < NC; i++) model_mem[i] = 8'h00;
    scan_vs_model("scan_after_reset");
    rd_x = 5'd28; rd_y = 5'd0; tick();
    check("rd_oor_x", int'(rd_data), 0);
    rd_x = 5'd0; rd_y = 5'd31; tick();
    check("rd_oor_y", int'(rd_data), 0);

    tap(4'b1000);
    m_x = 15;
    check("tap_right_once", int'(cursor_x), 15);

    // Held right key: expect step at press, then +20, +25, +30, +35.
    key_n = 4'b0111;
    prev  = int'(cursor_x);
    for (c = 0; c < 60; c++) begin
      if (c == 40) key_n = 4'hF;
      tick();
      if (int'(cursor_x) != prev) begin
        step_t.push_back(c);
        prev = int'(cursor_x);
      end
    end
    m_x = 20;
    check("hold_step_count", step_t.size(), 5);
    check("hold_final_x", int'(cursor_x), 20);
    if (step_t.size() == 5) begin
      check("hold_gap_delay", step_t[1] - step_t[0], 20);
      check("hold_gap_rate1", step_t[2] - step_t[1], 5);
      check("hold_gap_rate2", step_t[3] - step_t[2], 5);
      check("hold_gap_rate3", step_t[4] - step_t[3], 5);
    end

    move_to(0, 14);
    hold(4'b0100, 60);
    check("sat_left", int'(cursor_x), 0);
    move_to(27, 14);
    hold(4'b1000, 30);
    check("sat_right", int'(cursor_x), 27);
    tap(4'b0011);
    check("up_down_cancel", int'(cursor_y), 14);
    tap(4'b1100);
    check("left_right_cancel", int'(cursor_x), 27);

    vecs[0] = '{15, 14, 1'b1, 1'b0, 8'hFF};
    vecs[1] = '{15, 14, 1'b1, 1'b1, 8'h00};
    vecs[2] = '{15, 14, 1'b1, 1'b0, 8'hFF};
    vecs[3] = '{3, 5, 1'b1, 1'b0, 8'hFF};
    vecs[4] = '{3, 5, 1'b0, 1'b1, 8'h00};
    vecs[5] = '{0, 0, 1'b1, 1'b0, 8'hFF};
    vecs[6] = '{27, 27, 1'b1, 1'b0, 8'hFF};
    vecs[7] = '{27, 0, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < 8; i++) begin
      move_to(vecs[i].x, vecs[i].y);
      ink_op(vecs[i].draw, vecs[i].erase);
      rd_x = 5'(vecs[i].x);
      rd_y = 5'(vecs[i].y);
      tick();
      check("ink_table", int'(rd_data), int'(vecs[i].exp));
    end

    for (int i = 0; i < 8; i++) begin
      rx = $urandom_range(0, GW - 1);
      ry = $urandom_range(0, GH - 1);
      op = $urandom_range(0, 2);
      move_to(rx, ry);
      ink_op(op != 1, op != 0);
      rd_x = 5'(rx);
      rd_y = 5'(ry);
      tick();
      check("ink_random", int'(rd_data), int'(model_mem[ry * GW + rx]));
    end

    run_dump(1'b1);
    run_dump(1'b0);

    // Clear wins over a same-cycle dump; a dump request mid-clear is dropped.
    clear_req = 1'b1; dump_req = 1'b1;
    tick();
    clear_req = 1'b0; dump_req = 1'b0;
    n = 0; saw_valid = 1'b0;
    while (busy && n < 3000) begin
      dump_req = (n == 100);
      tick();
      n++;
      if (s_if.out_valid) saw_valid = 1'b1;
    end
    dump_req = 1'b0;
    check("clear_len", n, NC);
    check("clear_no_valid", int'(saw_valid), 0);
    repeat (5) tick();
    check("dump_during_clear_dropped_busy", int'(busy), 0);
    check("dump_during_clear_dropped_valid", int'(s_if.out_valid), 0);
    m_x = 14; m_y = 14;
    check("clear_recentre_x", int'(cursor_x), 14);
    check("clear_recentre_y", int'(cursor_y), 14);
    for (int i = 0; i < NC; i++) model_mem[i] = 8'h00;
    scan_vs_model("scan_after_clear");

    move_to(15, 14);
    ink_op(1'b1, 1'b0);
    dump_req = 1'b1; s_if.out_ready = 1'b1;
    tick();
    dump_req = 1'b0;
    repeat (50) tick();
    check("mid_dump_streaming", int'(s_if.out_valid), 1);
    resetn = 1'b0;
    #1;
    check("async_reset_valid", int'(s_if.out_valid), 0);
    check("async_reset_busy", int'(busy), 1);
    tick();
    resetn = 1'b1;
    s_if.out_ready = 1'b0;
    count_busy(n);
    check("abort_clear_len", n, NC);
    check("abort_cursor_x", int'(cursor_x), 14);
    check("abort_cursor_y", int'(cursor_y), 14);
    rd_x = 5'd15; rd_y = 5'd14; tick();
    check("abort_cell_cleared", int'(rd_data), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
